weight_enumerator: RTL and testbench
====================================

# weight_enumerator

Inverse companion to the 4-input population-count block. It accepts a one-hot weight code in the same v..z format that block produces (bit i set means "exactly i inputs high") and, over successive cycles, emits every 4-bit input word {a,b,c,d} with that weight on a valid/ready stream. It drives exhaustive stimulus into, or checks the inverse mapping of, the popcount logic inside the same tile.

## Interface
Parameters:
- DESCENDING, default 0: 0 emits words in ascending numeric order; 1 emits them in descending order.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- ena  in  1  tile enable; 0 freezes all state.
- cmd_valid  in  1  a weight command is offered.
- cmd_ready  out  1  the block can accept a command.
- weight  in  5  one-hot weight code; bit0 = v (weight 0) through bit4 = z (weight 4).
- out_valid  out  1  out_word is valid.
- out_ready  in  1  the consumer accepts out_word.
- out_word  out  4  the emitted word; bit3 = a, bit2 = b, bit1 = c, bit0 = d.
- out_last  out  1  the current out_word is the final word of the burst.
- err  out  1  one-cycle pulse when an invalid command is accepted.

## Operation
- States are IDLE and EMIT.
- In IDLE, cmd_ready = ena. A command is accepted when cmd_valid & cmd_ready.
- Accepting a valid command (exactly one bit of weight set):
  - Latch k, the weight encoded by the set bit.
  - Load the first word with popcount k: the smallest such word, or the largest when DESCENDING=1.
  - Move to EMIT.
- Accepting an invalid command (zero bits or two or more bits set):
  - Pulse err for one cycle.
  - Stay in IDLE.
  - Emit no words.
- In EMIT:
  - out_valid = ena.
  - A transfer occurs when out_valid & out_ready.
  - On a transfer, out_word advances to the next word in the chosen order with popcount k. The next word is computed combinationally from the current word, so there are no bubbles between words.
- out_last is high when no further word with popcount k exists in the chosen order.
  - Ascending last words per k: k=0 → 0000, k=1 → 1000, k=2 → 1100, k=3 → 1110, k=4 → 1111.
- A transfer while out_last is high returns the block to IDLE.
- Burst lengths per k: 1, 4, 6, 4, 1.
- cmd_ready is 0 throughout EMIT. Commands offered during a burst are neither accepted nor queued.
- When ena = 0:
  - cmd_ready and out_valid are forced to 0.
  - No handshakes occur.
  - State, the latched k and out_word are held.
  - out_word and out_last remain driven with their held values.

## Timing
- Reset: on a rising clk edge with rst=1, the state becomes IDLE.
  - Registered values become 0: out_word = 0000, out_last = 0, err = 0, latched k = 0.
  - cmd_ready = 0 and out_valid = 0 during the reset cycle.
  - rst takes priority over every other input.
  - Reset mid-burst abandons the burst with no out_last.
- Command acceptance edge T → out_valid = 1 and the first word present at T+1 (1-cycle latency).
- While out_valid = 1 and out_ready = 0, out_word and out_last are stable.
- A transfer of the last word at edge T → IDLE, with cmd_ready = ena at T+1. A new command may be accepted at T+1; there is no back-to-back command/last-word overlap.
- With out_ready held at 1, a weight-k burst occupies cycles T+1 .. T+N, where N is the burst length.
- err is high for exactly the one cycle following the accepting edge.
- out_valid does not depend combinationally on out_ready. cmd_ready does not depend combinationally on cmd_valid.

## Configuration
- WENUM_INDEX_EN defined:
  - Adds output port out_index (3 bits): the zero-based position of out_word within the current burst.
  - It is 0 on the first word and increments on each transfer.
  - It resets to 0 and holds at its value in IDLE.
- WENUM_INDEX_EN undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Weight 2, ascending:
  - Stimulus: weight = 00100, ascending, out_ready held at 1.
  - Required: out_word = 0011, 0101, 0110, 1001, 1010, 1100 on consecutive cycles; out_last only on 1100; cmd_ready = 1 on the next cycle.
- Weight 0:
  - Stimulus: weight = 00001.
  - Required: a single word 0000 with out_last = 1.
- Weight 4:
  - Stimulus: weight = 10000.
  - Required: a single word 1111 with out_last = 1.
- Invalid command:
  - Stimulus: weight = 00110, then weight = 00000.
  - Required: one err pulse each; out_valid stays 0; cmd_ready = 1 on the following cycle.
- Descending with backpressure:
  - Stimulus: DESCENDING=1, weight = 00010, out_ready toggling 1,0,0,1,...
  - Required: the sequence 1000, 0100, 0010, 0001, with each word held stable while out_ready = 0.
  - With WENUM_INDEX_EN: out_index = 0, 1, 2, 3.
- Reset and ena:
  - Stimulus: rst asserted after the third word of a weight-2 burst.
  - Required: IDLE with out_word = 0000 next cycle; a fresh weight-1 command then emits 0001 first.
  - Stimulus: ena = 0 for 3 cycles mid-burst.
  - Required: no transfers during those cycles; the burst resumes with the same word.

Source files
------------

// File: rtl/weight_enumerator.sv
// weight_enumerator: streams every 4-bit word whose popcount matches a one-hot weight code.
// Optional out_index port and burst-position counter enabled by defining WENUM_INDEX_EN.
module weight_enumerator #(
    parameter bit DESCENDING = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [4:0] weight,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_word,
    output logic       out_last,
    output logic       err
`ifdef WENUM_INDEX_EN
    ,
    output logic [2:0] out_index
`endif
);
    localparam logic IDLE = 1'b0;
    localparam logic EMIT = 1'b1;

    logic       state_q, state_d;
    logic [2:0] k_q, k_d;
    logic [3:0] word_q, word_d;
    logic       err_q, err_d;
    logic       onehot, load, xfer, has_next;
    logic [2:0] cmd_k;
    logic [3:0] first_word, next_word, cand;

    function automatic logic [2:0] pop4(input logic [3:0] w);
        return 3'(w[0]) + 3'(w[1]) + 3'(w[2]) + 3'(w[3]);
    endfunction

    // Scan order makes the last match the nearest word in the chosen direction.
    always_comb begin
        has_next = 1'b0;
        next_word = word_q;
        cand = 4'd0;
        for (int j = 0; j < 16; j++) begin
            cand = DESCENDING ? 4'(j) : 4'(15 - j);
            if ((DESCENDING ? cand < word_q : cand > word_q) && pop4(cand) == k_q) begin
                has_next = 1'b1;
                next_word = cand;
            end
        end
    end

    always_comb begin
        onehot = (weight != 5'd0) && ((weight & (weight - 5'd1)) == 5'd0);
        cmd_k = weight[4] ? 3'd4 : weight[3] ? 3'd3 : weight[2] ? 3'd2 : weight[1] ? 3'd1 : 3'd0;
        first_word = DESCENDING ? ~4'((5'd1 << (3'd4 - cmd_k)) - 5'd1)
                                : 4'((5'd1 << cmd_k) - 5'd1);
        cmd_ready = ena & ~rst & (state_q == IDLE);
        out_valid = ena & ~rst & (state_q == EMIT);
        load = cmd_valid & cmd_ready & onehot;
        xfer = out_valid & out_ready;
        state_d = load ? EMIT : (xfer & ~has_next) ? IDLE : state_q;
        k_d = load ? cmd_k : k_q;
        word_d = load ? first_word : (xfer & has_next) ? next_word : word_q;
        err_d = cmd_valid & cmd_ready & ~onehot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q <= 3'd0;
            word_q <= 4'd0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            word_q <= word_d;
            err_q <= err_d;
        end
    end

    assign out_word = word_q;
    assign out_last = (state_q == EMIT) & ~has_next;
    assign err = err_q;

`ifdef WENUM_INDEX_EN
    logic [2:0] idx_q, idx_d;

    always_comb begin
        idx_d = load ? 3'd0 : (xfer & has_next) ? idx_q + 3'd1 : idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) idx_q <= 3'd0;
        else idx_q <= idx_d;
    end

    assign out_index = idx_q;
`endif
endmodule

// File: tb/tb_weight_enumerator.sv
// tb_weight_enumerator: scoreboard bench with ascending and descending instances.
module tb_weight_enumerator;
    logic clk = 1'b0, rst = 1'b1, ena = 1'b1;
    logic a_cmd_valid = 1'b0, a_cmd_ready, a_out_valid, a_out_ready = 1'b1, a_out_last, a_err;
    logic d_cmd_valid = 1'b0, d_cmd_ready, d_out_valid, d_out_ready = 1'b1, d_out_last, d_err;
    logic [4:0] a_weight = 5'd0, d_weight = 5'd0;
    logic [3:0] a_out_word, d_out_word;
`ifdef WENUM_INDEX_EN
    logic [2:0] a_out_index, d_out_index;
`endif
    int checks = 0, errors = 0;

    typedef struct {
        logic [3:0] w;
        logic       l;
        logic [2:0] i;
    } exp_t;
    exp_t aq[$], dq[$];

    always #5 clk = ~clk;

    weight_enumerator #(.DESCENDING(1'b0)) u_asc (
        .clk(clk), .rst(rst), .ena(ena), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .weight(a_weight), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_word(a_out_word), .out_last(a_out_last), .err(a_err)
`ifdef WENUM_INDEX_EN
        , .out_index(a_out_index)
`endif
    );

    weight_enumerator #(.DESCENDING(1'b1)) u_desc (
        .clk(clk), .rst(rst), .ena(ena), .cmd_valid(d_cmd_valid), .cmd_ready(d_cmd_ready),
        .weight(d_weight), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_word(d_out_word), .out_last(d_out_last), .err(d_err)
`ifdef WENUM_INDEX_EN
        , .out_index(d_out_index)
`endif
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Words are listed first-to-last, one nibble each, most significant nibble first.
    task automatic push(input bit d, input logic [23:0] ws, input int n, input bit has_last);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.w = ws[4*(n-1-i) +: 4];
            e.l = has_last && (i == n - 1);
            e.i = 3'(i);
            if (d) dq.push_back(e);
            else aq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (a_out_valid) begin
            if (aq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected: got word %b, expected no output", a_out_word);
            end else begin
                check("a_word", 8'(a_out_word), 8'(aq[0].w));
                check("a_last", 8'(a_out_last), 8'(aq[0].l));
`ifdef WENUM_INDEX_EN
                check("a_index", 8'(a_out_index), 8'(aq[0].i));
`endif
                if (a_out_ready) void'(aq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (d_out_valid) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d_unexpected: got word %b, expected no output", d_out_word);
            end else begin
                check("d_word", 8'(d_out_word), 8'(dq[0].w));
                check("d_last", 8'(d_out_last), 8'(dq[0].l));
`ifdef WENUM_INDEX_EN
                check("d_index", 8'(d_out_index), 8'(dq[0].i));
`endif
                if (d_out_ready) void'(dq.pop_front());
            end
        end
    end

    task automatic cmd_a(input logic [4:0] w, input bit good);
        a_weight = w;
        a_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        a_cmd_valid = 1'b0;
        check("a_first_valid", 8'(a_out_valid), 8'(good));
        check("a_err_pulse", 8'(a_err), 8'(!good));
    endtask

    task automatic drain_a(input int want);
        int n = 0;
        while (aq.size() != 0 && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("a_burst_cycles", 8'(n), 8'(want));
        aq.delete();
    endtask

    task automatic idle_a(input string name);
        check(name, 8'({a_cmd_ready, a_out_valid, a_err}), 8'(3'b100));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        check("rst_cmd_ready", 8'(a_cmd_ready), 8'd0);
        check("rst_out_valid", 8'(a_out_valid), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_word", 8'(a_out_word), 8'd0);
        check("rst_last", 8'(a_out_last), 8'd0);
        idle_a("rst_idle");
`ifdef WENUM_INDEX_EN
        check("rst_index", 8'(a_out_index), 8'd0);
`endif
        push(0, 24'h3569AC, 6, 1);
        cmd_a(5'b00100, 1);
        drain_a(6);
        idle_a("w2_after");
        push(0, 24'h0, 1, 1);
        cmd_a(5'b00001, 1);
        drain_a(1);
        idle_a("w0_after");
        push(0, 24'hF, 1, 1);
        cmd_a(5'b10000, 1);
        drain_a(1);
        idle_a("w4_after");
        cmd_a(5'b00110, 0);
        #10;
        idle_a("inv2_after");
        cmd_a(5'b00000, 0);
        #10;
        idle_a("inv0_after");

        push(1, 24'h8421, 4, 1);
        d_weight = 5'b00010;
        d_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        d_cmd_valid = 1'b0;
        check("d_first_valid", 8'(d_out_valid), 8'd1);
        for (int i = 0; i < 40 && dq.size() != 0; i++) begin
            d_out_ready = (i % 3 == 0);
            @(posedge clk);
            #1;
        end
        check("d_drained", 8'(dq.size()), 8'd0);
        dq.delete();
        d_out_ready = 1'b1;
        check("d_cmd_ready_after", 8'(d_cmd_ready), 8'd1);

        push(0, 24'h356, 3, 0);
        cmd_a(5'b00100, 1);
        drain_a(3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_word", 8'(a_out_word), 8'd0);
        check("mid_rst_last", 8'(a_out_last), 8'd0);
        idle_a("mid_rst_idle");
`ifdef WENUM_INDEX_EN
        check("mid_rst_index", 8'(a_out_index), 8'd0);
`endif
        push(0, 24'h1248, 4, 1);
        cmd_a(5'b00010, 1);
        drain_a(4);

        push(0, 24'h7BDE, 4, 1);
        cmd_a(5'b01000, 1);
        @(posedge clk);
        #1;
        ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("ena_out_valid", 8'(a_out_valid), 8'd0);
            check("ena_cmd_ready", 8'(a_cmd_ready), 8'd0);
            check("ena_word_held", 8'(a_out_word), 8'hB);
            check("ena_last_held", 8'(a_out_last), 8'd0);
        end
        @(posedge clk);
        #1;
        ena = 1'b1;
        drain_a(3);
        idle_a("ena_after");

        check("a_queue_empty", 8'(aq.size()), 8'd0);
        check("d_queue_empty", 8'(dq.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
